// File: rtl/mc_cu_pkg.sv
// Shared types for the multi-cycle RV32I control unit: FSM states, instruction
// classes, opcode values and datapath select encodings.
package mc_cu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CLS_R      = 4'd0,
    CLS_I      = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_LUI    = 4'd5,
    CLS_AUIPC  = 4'd6,
    CLS_JAL    = 4'd7,
    CLS_JALR   = 4'd8,
    CLS_ILL    = 4'd15
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_PASSB = 2'b11;

  localparam logic       SRC_A_RS1  = 1'b0;
  localparam logic       SRC_A_PC   = 1'b1;
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_MEM  = 2'b01;
  localparam logic [1:0] RES_LINK = 2'b10;

  function automatic logic [1:0] wb_result_src(cls_e c);
    case (c)
      CLS_LOAD:           return RES_MEM;
      CLS_JAL, CLS_JALR:  return RES_LINK;
      default:            return RES_ALU;
    endcase
  endfunction

endpackage

// File: rtl/mc_cu_if.sv
// Control-unit <-> datapath/memory bundle. The control unit is the master;
// the datapath and memory side use the slave view.
interface mc_cu_if #(
  parameter int CNT_W = 32
);
  logic             en;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic [1:0]       result_src;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic             branch;
  logic             jump;
  logic             instr_done;
  logic [CNT_W-1:0] instret;
  logic             illegal;
  logic             bus_err;
  logic [2:0]       state;

  modport master (
    input  en, opcode, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, branch, jump,
           instr_done, instret, illegal, bus_err, state
  );

  modport slave (
    output en, opcode, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, branch, jump,
           instr_done, instret, illegal, bus_err, state
  );
endinterface

// File: rtl/mc_cu_decode.sv
// Opcode -> instruction class and legality. JAL/JALR are only recognised
// when CU_JUMP_EN is defined; otherwise they decode as illegal.
module mc_cu_decode
  import mc_cu_pkg::*;
(
  input  logic [6:0] opcode,
  output cls_e       cls,
  output logic       legal
);

  // Class lookup; anything not listed falls into CLS_ILL.
  always_comb begin
    cls   = CLS_ILL;
    legal = 1'b0;
    case (opcode)
      OP_R:      cls = CLS_R;
      OP_I:      cls = CLS_I;
      OP_LOAD:   cls = CLS_LOAD;
      OP_STORE:  cls = CLS_STORE;
      OP_BRANCH: cls = CLS_BRANCH;
      OP_LUI:    cls = CLS_LUI;
      OP_AUIPC:  cls = CLS_AUIPC;
`ifdef CU_JUMP_EN
      OP_JAL:    cls = CLS_JAL;
      OP_JALR:   cls = CLS_JALR;
`endif
      default:   cls = CLS_ILL;
    endcase
    legal = (cls != CLS_ILL);
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I control FSM with memory-ready handshake, wait timeout,
// sticky fault flags and retire counter. Optional JAL/JALR via CU_JUMP_EN.
module mc_control_unit
  import mc_cu_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 16,
  parameter int CNT_W        = 32
) (
  input  logic    clk,
  input  logic    rst_n,
  mc_cu_if.master bus
);

  localparam int WAIT_W = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam bit TO_EN  = (MEM_WAIT_MAX > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_WAIT_MAX > 0) ? WAIT_W'(MEM_WAIT_MAX - 1) : '0;

  state_e             state_q, state_d;
  logic [6:0]         opcode_q, opcode_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;

  logic [6:0] dec_opcode_s;
  cls_e       cls_s;
  logic       legal_s;
  logic       timeout_s;

  logic       pc_write_s, ir_write_s, i_or_d_s, mem_read_s, mem_write_s;
  logic       reg_write_s, alu_src_a_s, branch_s, jump_s, instr_done_s;
  logic [1:0] result_src_s, alu_src_b_s, alu_op_s;

  // DECODE classifies the live IR opcode; later states use the captured copy.
  assign dec_opcode_s = (state_q == ST_DECODE) ? bus.opcode : opcode_q;

  mc_cu_decode u_decode (
    .opcode (dec_opcode_s),
    .cls    (cls_s),
    .legal  (legal_s)
  );

  // The current cycle is the last allowed wait if mem_ready does not arrive now.
  assign timeout_s = TO_EN && (wait_q == WAIT_LAST);

  // Next-state, flag updates and datapath controls.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    illegal_d    = illegal_q;
    bus_err_d    = bus_err_q;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    i_or_d_s     = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    result_src_s = RES_ALU;
    alu_src_a_s  = SRC_A_RS1;
    alu_src_b_s  = SRC_B_RS2;
    alu_op_s     = ALU_ADD;
    branch_s     = 1'b0;
    jump_s       = 1'b0;
    instr_done_s = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (bus.en) begin
          mem_read_s  = 1'b1;
          alu_src_a_s = SRC_A_PC;
          alu_src_b_s = SRC_B_FOUR;
          alu_op_s    = ALU_ADD;
          if (bus.mem_ready) begin
            ir_write_s = 1'b1;
            pc_write_s = 1'b1;
            state_d    = ST_DECODE;
          end else if (timeout_s) begin
            bus_err_d = 1'b1;
            state_d   = ST_TRAP;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_DECODE: begin
        alu_src_a_s = SRC_A_PC;
        alu_src_b_s = SRC_B_IMM;
        alu_op_s    = ALU_ADD;
        opcode_d    = bus.opcode;
        if (legal_s) begin
          state_d = ST_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = ST_TRAP;
        end
      end

      ST_EXEC: begin
        case (cls_s)
          CLS_R: begin
            alu_op_s = ALU_FUNCT;
            state_d  = ST_WB;
          end
          CLS_I: begin
            alu_src_b_s = SRC_B_IMM;
            alu_op_s    = ALU_FUNCT;
            state_d     = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_src_b_s = SRC_B_IMM;
            state_d     = ST_MEM;
          end
          CLS_BRANCH: begin
            alu_op_s     = ALU_BR;
            branch_s     = 1'b1;
            instr_done_s = 1'b1;
            state_d      = ST_FETCH;
          end
          CLS_LUI: begin
            alu_src_b_s = SRC_B_IMM;
            alu_op_s    = ALU_PASSB;
            state_d     = ST_WB;
          end
          CLS_AUIPC: begin
            alu_src_a_s = SRC_A_PC;
            alu_src_b_s = SRC_B_IMM;
            state_d     = ST_WB;
          end
`ifdef CU_JUMP_EN
          CLS_JAL, CLS_JALR: begin
            jump_s      = 1'b1;
            pc_write_s  = 1'b1;
            alu_src_a_s = (cls_s == CLS_JAL) ? SRC_A_PC : SRC_A_RS1;
            alu_src_b_s = SRC_B_IMM;
            state_d     = ST_WB;
          end
`endif
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_TRAP;
          end
        endcase
      end

      ST_MEM: begin
        i_or_d_s    = 1'b1;
        mem_read_s  = (cls_s == CLS_LOAD);
        mem_write_s = (cls_s != CLS_LOAD);
        if (bus.mem_ready) begin
          instr_done_s = (cls_s != CLS_LOAD);
          state_d      = (cls_s == CLS_LOAD) ? ST_WB : ST_FETCH;
        end else if (timeout_s) begin
          bus_err_d = 1'b1;
          state_d   = ST_TRAP;
        end else begin
          state_d = ST_MEM;
        end
      end

      ST_WB: begin
        reg_write_s  = 1'b1;
        result_src_s = wb_result_src(cls_s);
        instr_done_s = 1'b1;
        state_d      = ST_FETCH;
      end

      ST_TRAP: state_d = ST_TRAP;

      default: state_d = ST_TRAP;
    endcase
  end

  // Wait counter only advances on strobe cycles still lacking mem_ready,
  // so it is zero on every entry to FETCH or MEM.
  always_comb begin
    wait_d = '0;
    if (TO_EN && (mem_read_s || mem_write_s) && !bus.mem_ready) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end
  end

  // Retire counter wraps naturally at 2^CNT_W.
  always_comb begin
    instret_d = instret_q;
    if (instr_done_s) begin
      instret_d = instret_q + CNT_W'(1);
    end else begin
      instret_d = instret_q;
    end
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      opcode_q  <= 7'd0;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Controls are forced low while reset is held, even with en high in FETCH.
  assign bus.pc_write   = rst_n & pc_write_s;
  assign bus.ir_write   = rst_n & ir_write_s;
  assign bus.i_or_d     = rst_n & i_or_d_s;
  assign bus.mem_read   = rst_n & mem_read_s;
  assign bus.mem_write  = rst_n & mem_write_s;
  assign bus.reg_write  = rst_n & reg_write_s;
  assign bus.result_src = rst_n ? result_src_s : 2'b00;
  assign bus.alu_src_a  = rst_n & alu_src_a_s;
  assign bus.alu_src_b  = rst_n ? alu_src_b_s : 2'b00;
  assign bus.alu_op     = rst_n ? alu_op_s : 2'b00;
  assign bus.branch     = rst_n & branch_s;
  assign bus.jump       = rst_n & jump_s;
  assign bus.instr_done = rst_n & instr_done_s;
  assign bus.instret    = instret_q;
  assign bus.illegal    = illegal_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit (MEM_WAIT_MAX = 4, CNT_W = 4).
module tb_mc_control_unit;

  localparam int MAXW = 4;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4;
  localparam int K_LUI = 5, K_AUI = 6, K_JAL = 7, K_JALR = 8, K_ILL = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mc_cu_if #(.CNT_W(4)) bus();

  mc_control_unit #(.MEM_WAIT_MAX(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] st;
    logic rd, wr, iod, irw, pcw, rw;
    logic [1:0] rs;
    logic a;
    logic [1:0] b, op;
    logic br, jmp, done;
  } outv_t;

  typedef struct {
    logic [6:0] op;
    int fw, mw, cyc, stb;
    bit ill, berr;
    int ret;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  function automatic outv_t sample();
    outv_t v;
    v.st = bus.state; v.rd = bus.mem_read; v.wr = bus.mem_write;
    v.iod = bus.i_or_d; v.irw = bus.ir_write; v.pcw = bus.pc_write;
    v.rw = bus.reg_write; v.rs = bus.result_src; v.a = bus.alu_src_a;
    v.b = bus.alu_src_b; v.op = bus.alu_op; v.br = bus.branch;
    v.jmp = bus.jump; v.done = bus.instr_done;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input outv_t exp);
    outv_t act;
    act = sample();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b (st rd wr iod irw pcw rw rs a b op br jmp done)",
               tag, act, exp);
    end
  endtask

  function automatic int kind(input logic [6:0] op);
    case (op)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b1100011: return K_BR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUI;
`ifdef CU_JUMP_EN
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
`endif
      default:    return K_ILL;
    endcase
  endfunction

  // Expected control word for each phase, straight from the operation table.
  function automatic outv_t v_fetch(input bit rdy);
    outv_t v = '0;
    v.rd = 1'b1; v.a = 1'b1; v.b = 2'b10; v.irw = rdy; v.pcw = rdy;
    return v;
  endfunction

  function automatic outv_t v_decode();
    outv_t v = '0;
    v.st = 3'd1; v.a = 1'b1; v.b = 2'b01;
    return v;
  endfunction

  function automatic outv_t v_exec(input int k);
    outv_t v = '0;
    v.st = 3'd2;
    case (k)
      K_R:       v.op = 2'b10;
      K_I:       begin v.b = 2'b01; v.op = 2'b10; end
      K_LD, K_ST: v.b = 2'b01;
      K_BR:      begin v.op = 2'b01; v.br = 1'b1; v.done = 1'b1; end
      K_LUI:     begin v.b = 2'b01; v.op = 2'b11; end
      K_AUI:     begin v.a = 1'b1; v.b = 2'b01; end
      K_JAL:     begin v.jmp = 1'b1; v.pcw = 1'b1; v.a = 1'b1; v.b = 2'b01; end
      K_JALR:    begin v.jmp = 1'b1; v.pcw = 1'b1; v.b = 2'b01; end
      default:   v = '0;
    endcase
    return v;
  endfunction

  function automatic outv_t v_mem(input bit ld, input bit rdy);
    outv_t v = '0;
    v.st = 3'd3; v.iod = 1'b1; v.rd = ld; v.wr = !ld; v.done = !ld && rdy;
    return v;
  endfunction

  function automatic outv_t v_wb(input int k);
    outv_t v = '0;
    v.st = 3'd4; v.rw = 1'b1; v.done = 1'b1;
    v.rs = (k == K_LD) ? 2'b01 : ((k == K_JAL || k == K_JALR) ? 2'b10 : 2'b00);
    return v;
  endfunction

  function automatic outv_t v_trap();
    outv_t v = '0;
    v.st = 3'd7;
    return v;
  endfunction

  // One clock: drive mem_ready, compare on the falling edge, move past the rising edge.
  task automatic cyc(input bit rdy, input outv_t exp, input string tag);
    bus.mem_ready = rdy;
    @(negedge clk);
    chk_vec(tag, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.en = 1'b0; bus.mem_ready = 1'b0; bus.opcode = 7'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = 0;
  endtask

  // Memory access of w not-ready cycles; ok=0 when the wait limit is hit.
  task automatic access(input bit fetch, input bit ld, input int w, input string tag,
                        output bit ok);
    ok = 1'b1;
    for (int i = 0; i <= w; i++) begin
      cyc(i == w, fetch ? v_fetch(i == w) : v_mem(ld, i == w), tag);
      if (i != w && i == MAXW - 1) begin
        ok = 1'b0;
        return;
      end
    end
  endtask

  // Drives one instruction and checks every cycle's control word plus counters.
  task automatic run_trace(input logic [6:0] op, input int fw, input int mw,
                           input string tag);
    int k;
    bit ok;
    bit exp_ill, exp_berr;
    k = kind(op);
    exp_ill = 1'b0; exp_berr = 1'b0;
    bus.en = 1'b1; bus.opcode = op;
    access(1'b1, 1'b0, fw, tag, ok);
    if (!ok) exp_berr = 1'b1;
    else begin
      cyc($urandom_range(0, 1), v_decode(), tag);
      if (k == K_ILL) exp_ill = 1'b1;
      else begin
        cyc($urandom_range(0, 1), v_exec(k), tag);
        if (k == K_LD || k == K_ST) begin
          access(1'b0, k == K_LD, mw, tag, ok);
          if (!ok) exp_berr = 1'b1;
        end
        if (ok && k != K_BR && k != K_ST) cyc($urandom_range(0, 1), v_wb(k), tag);
        if (ok) exp_cnt = (exp_cnt + 1) % 16;
      end
    end
    chk({tag, "_instret"}, 32'(bus.instret), 32'(exp_cnt));
    chk({tag, "_flags"}, {30'd0, bus.illegal, bus.bus_err}, {30'd0, exp_ill, exp_berr});
  endtask

  // Table entry run with a simple memory responder reacting to the strobes.
  task automatic run_vec(input vec_t v, input int idx);
    int cycles, strobes, scnt, lim;
    bit strobe, done, trapped;
    string tag;
    tag = $sformatf("vec%0d", idx);
    do_reset();
    cycles = 0; strobes = 0; scnt = 0; done = 1'b0; trapped = 1'b0;
    bus.en = 1'b1; bus.opcode = v.op;
    for (int c = 0; c < 40; c++) begin
      #1;
      strobe = bus.mem_read | bus.mem_write;
      lim = bus.i_or_d ? v.mw : v.fw;
      bus.mem_ready = strobe && (scnt == lim);
      @(negedge clk);
      if (bus.state == 3'd7) begin
        trapped = 1'b1;
        break;
      end
      cycles++;
      if (strobe) scnt++; else scnt = 0;
      if (strobe) strobes++;
      if (bus.instr_done) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
    end
    if (done) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_cycles"}, 32'(cycles), 32'(v.cyc));
    chk({tag, "_strobes"}, 32'(strobes), 32'(v.stb));
    chk({tag, "_trap"}, 32'(trapped), 32'(v.ill | v.berr));
    chk({tag, "_illegal"}, 32'(bus.illegal), 32'(v.ill));
    chk({tag, "_bus_err"}, 32'(bus.bus_err), 32'(v.berr));
    chk({tag, "_instret"}, 32'(bus.instret), 32'(v.ret));
    if (trapped) chk({tag, "_strobe_drop"}, 32'(bus.mem_read | bus.mem_write), 32'd0);
  endtask

  vec_t tbl[14];
  logic [6:0] ops[9];

  initial begin
    tbl[0]  = '{7'b0110011, 0, 0, 4, 1, 1'b0, 1'b0, 1};
    tbl[1]  = '{7'b0010011, 1, 0, 5, 2, 1'b0, 1'b0, 1};
    tbl[2]  = '{7'b0000011, 0, 3, 8, 5, 1'b0, 1'b0, 1};
    tbl[3]  = '{7'b0100011, 0, 0, 4, 2, 1'b0, 1'b0, 1};
    tbl[4]  = '{7'b0100011, 0, 2, 6, 4, 1'b0, 1'b0, 1};
    tbl[5]  = '{7'b1100011, 2, 0, 5, 3, 1'b0, 1'b0, 1};
    tbl[6]  = '{7'b0110111, 0, 0, 4, 1, 1'b0, 1'b0, 1};
    tbl[7]  = '{7'b0010111, 0, 0, 4, 1, 1'b0, 1'b0, 1};
    tbl[8]  = '{7'b0000000, 0, 0, 2, 1, 1'b1, 1'b0, 0};
    tbl[9]  = '{7'b0110011, 7, 0, 4, 4, 1'b0, 1'b1, 0};
    tbl[10] = '{7'b0000011, 0, 7, 7, 5, 1'b0, 1'b1, 0};
    tbl[11] = '{7'b0000011, 3, 0, 8, 5, 1'b0, 1'b0, 1};
`ifdef CU_JUMP_EN
    tbl[12] = '{7'b1101111, 0, 0, 4, 1, 1'b0, 1'b0, 1};
    tbl[13] = '{7'b1100111, 0, 0, 4, 1, 1'b0, 1'b0, 1};
`else
    tbl[12] = '{7'b1101111, 0, 0, 2, 1, 1'b1, 1'b0, 0};
    tbl[13] = '{7'b1100111, 0, 0, 2, 1, 1'b1, 1'b0, 0};
`endif
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

    // Reset state, with en already high while reset is held.
    bus.en = 1'b1; bus.mem_ready = 1'b1; bus.opcode = 7'b0110011;
    #3;
    chk_vec("reset_outputs", '0);
    chk("reset_instret", 32'(bus.instret), 32'd0);
    chk("reset_flags", {30'd0, bus.illegal, bus.bus_err}, 32'd0);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // R-type trace, then JAL/JALR traces (illegal without the jump option).
    do_reset();
    run_trace(7'b0110011, 0, 0, "rtype");
    run_trace(7'b0000011, 0, 3, "load_wait3");
    do_reset();
    run_trace(7'b1101111, 0, 0, "jal");
    do_reset();
    run_trace(7'b1100111, 0, 0, "jalr");

    // Reset mid-MEM of a store.
    do_reset();
    run_trace(7'b1100011, 0, 0, "pre_br");
    bus.en = 1'b1; bus.opcode = 7'b0100011;
    cyc(1'b1, v_fetch(1'b1), "rst_st_f");
    cyc(1'b0, v_decode(), "rst_st_d");
    cyc(1'b0, v_exec(K_ST), "rst_st_e");
    cyc(1'b0, v_mem(1'b0, 1'b0), "rst_st_m");
    #2 rst_n = 1'b0;
    #1;
    chk_vec("rst_mid_outputs", '0);
    chk("rst_mid_instret", 32'(bus.instret), 32'd0);
    bus.en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_cnt = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1, '0, "rst_release_idle");

    // Illegal opcode: TRAP holds under input toggling.
    do_reset();
    run_trace(7'b0000000, 0, 0, "illegal");
    for (int i = 0; i < 8; i++) begin
      bus.en = 1'($urandom_range(0, 1));
      cyc(1'($urandom_range(0, 1)), v_trap(), "trap_hold");
    end
    chk("trap_illegal_sticky", 32'(bus.illegal), 32'd1);

    // Counter wrap after 16 branches.
    do_reset();
    for (int i = 0; i < 15; i++) run_trace(7'b1100011, 0, 0, "br_wrap");
    chk("instret_15", 32'(bus.instret), 32'd15);
    run_trace(7'b1100011, 0, 0, "br_wrap");
    chk("instret_wrap0", 32'(bus.instret), 32'd0);

    // Randomized legal programs with idle gaps and memory waits.
    do_reset();
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      int idle;
      op = ops[$urandom_range(0, 8)];
      while (kind(op) == K_ILL) op = ops[$urandom_range(0, 8)];
      idle = $urandom_range(0, 2);
      bus.en = 1'b0;
      for (int j = 0; j < idle; j++) cyc(1'($urandom_range(0, 1)), '0, "rand_idle");
      run_trace(op, $urandom_range(0, 2), $urandom_range(0, 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
